// File: rtl/sr_exerciser_pkg.sv
// Purpose: shared constants and the expected-response table for the SR latch exerciser.
// Latency: n/a (package only).
// Backpressure: n/a.
package sr_exerciser_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_INIT     = 3'd1;
    localparam logic [2:0] ST_INIT_REL = 3'd2;
    localparam logic [2:0] ST_DRIVE    = 3'd3;
    localparam logic [2:0] ST_RELEASE  = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    // Phase index used to address the expected-value table
    localparam logic [1:0] PH_INIT_REL = 2'd0;
    localparam logic [1:0] PH_DRIVE    = 2'd1;
    localparam logic [1:0] PH_RELEASE  = 2'd2;

    localparam logic [3:0] ERR_MAX = 4'd15;

    typedef struct packed {
        logic q;
        logic qn;
        logic chk_en;
    } exp_t;

    // Expected {q, qn} and check enable, indexed by {phase, step}.
    // Most entries are the reset-held (0,1); only the set vectors and the
    // forbidden (1,1) drive differ. Releasing (1,1) is a race, so unchecked.
    function automatic exp_t exp_lookup(input logic [1:0] phase, input logic [1:0] step);
        exp_t e;
        e = '{q: 1'b0, qn: 1'b1, chk_en: 1'b1};
        case ({phase, step})
            {PH_DRIVE, 2'd2},
            {PH_RELEASE, 2'd2}: e = '{q: 1'b1, qn: 1'b0, chk_en: 1'b1};
            {PH_DRIVE, 2'd3}:   e = '{q: 1'b0, qn: 1'b0, chk_en: 1'b1};
            {PH_RELEASE, 2'd3}: e = '{q: 1'b0, qn: 1'b0, chk_en: 1'b0};
            default: begin
                if (phase == 2'd3) begin
                    e.chk_en = 1'b0;
                end
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Purpose: two-flop synchroniser for asynchronous inputs, synchronous reset to 0.
// Latency: 2 clk cycles from d_i to q_o.
// Backpressure: none; free-running.
// Ports: clk, reset (sync, active-high), d_i (async in), q_o (synchronised out).
module sync_2ff #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sr_latch_exerciser.sv
// Purpose: drives the NOR SR latch through its truth table, checks q/qn, reports pass/err_count.
// Latency: one run is 10*HOLD_CYCLES cycles; done rises 10*HOLD_CYCLES+1 cycles after start is sampled.
// Backpressure: start is ignored while busy; results hold in DONE until the next start (or auto-restart if LOOP).
// Ports: clk, reset (sync, active-high), start; s_out/r_out latch drive; q_in/qn_in async latch outputs;
//        busy, done, pass, err_count[3:0], step[1:0] status (all registered).
module sr_latch_exerciser
    import sr_exerciser_pkg::*;
#(
    parameter int HOLD_CYCLES = 10,
    parameter bit LOOP        = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       s_out,
    output logic       r_out,
    input  logic       q_in,
    input  logic       qn_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [1:0] step
);

    localparam int             CW       = $clog2(HOLD_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(HOLD_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    step_q, step_d;
    logic [3:0]    err_q, err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic          s_q, s_d;
    logic          r_q, r_d;

    logic [1:0]    qq_sync;
    logic [1:0]    phase;
    exp_t          exp_v;
    logic          last;
    logic          chk_state;
    logic          mismatch;
    logic          restart;

    sync_2ff #(.WIDTH(2)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   ({q_in, qn_in}),
        .q_o   (qq_sync)
    );

    assign last      = (cnt_q == CNT_LAST);
    assign chk_state = (state_q == ST_INIT_REL) || (state_q == ST_DRIVE) || (state_q == ST_RELEASE);
    assign phase     = (state_q == ST_DRIVE)   ? PH_DRIVE :
                       (state_q == ST_RELEASE) ? PH_RELEASE : PH_INIT_REL;
    assign exp_v     = exp_lookup(phase, step_q);
    assign mismatch  = (qq_sync != {exp_v.q, exp_v.qn});

    // In LOOP mode the restart waits until done has been visible for one cycle.
    assign restart   = ((state_q == ST_IDLE) && start) ||
                       ((state_q == ST_DONE) && (start || (LOOP && done_q)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;

        if (chk_state || (state_q == ST_INIT)) begin
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end else begin
            cnt_d = '0;
        end

        if (chk_state && last && exp_v.chk_en && mismatch && (err_q != ERR_MAX)) begin
            err_d = err_q + 4'd1;
        end

        case (state_q)
            ST_INIT:     if (last) state_d = ST_INIT_REL;
            ST_INIT_REL: if (last) state_d = ST_DRIVE;
            ST_DRIVE:    if (last) state_d = ST_RELEASE;
            ST_RELEASE: begin
                if (last) begin
                    if (step_q == 2'd3) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRIVE;
                        step_d  = step_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                pass_d = (err_q == 4'd0);
            end
            default: state_d = ST_IDLE;
        endcase

        if (restart) begin
            state_d = ST_INIT;
            cnt_d   = '0;
            step_d  = 2'd0;
            err_d   = 4'd0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
            pass_d  = 1'b0;
        end

        // Drives follow the next state so they change on the same edge as the FSM.
        s_d = (state_d == ST_DRIVE) && step_d[1];
        r_d = (state_d == ST_INIT) || ((state_d == ST_DRIVE) && step_d[0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            step_q  <= 2'd0;
            err_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            s_q     <= s_d;
            r_q     <= r_d;
        end
    end

    assign s_out     = s_q;
    assign r_out     = r_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;
    assign step      = step_q;

endmodule

// File: doc/sr_latch_exerciser.md
Name: sr_latch_exerciser

Overview:
- Clocked on-chip driver and checker for the cross-coupled NOR SR latch. It is the active end of the latch's s/r/q/qn interface.
- Drives the full (s,r) truth-table sequence with hold and release phases on s_out/r_out.
- Synchronises the latch's q/qn back into the clock domain and compares them against expected values at fixed points.
- Reports pass/fail and an error count, so the latch can be self-tested on the board without a simulator.

Parameters:
- HOLD_CYCLES, 10: clock cycles per drive or release phase. Must be >= 4 to cover synchroniser latency.
- LOOP, 0: 0 = run one sequence per start. 1 = restart automatically after DONE.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a test sequence; sampled only in IDLE or DONE
- s_out  out  1  set drive to the latch
- r_out  out  1  reset drive to the latch
- q_in  in  1  latch q, asynchronous
- qn_in  in  1  latch qn, asynchronous
- busy  out  1  sequence in progress
- done  out  1  sequence finished; level, held until next start
- pass  out  1  valid while done=1; 1 when err_count==0
- err_count  out  4  mismatches this run; saturates at 15
- step  out  2  current vector index 0..3

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous and active-high.
  - Reset value of every output is 0: s_out, r_out, busy, done, pass, err_count, step. The FSM returns to IDLE.
  - Reset asserted mid-run aborts the sequence. Outputs take their reset values at the next edge.
- Outputs: all are registered.
- Inputs: q_in and qn_in each pass through a 2-flop synchroniser before any comparison.
- Phase counter: counts 0..HOLD_CYCLES-1 within each phase. The check happens on the last cycle of the phase (count==HOLD_CYCLES-1), using the synchronised q/qn.
- FSM states: IDLE, INIT, INIT_REL, DRIVE, RELEASE, DONE.
- IDLE:
  - s_out=r_out=0.
  - start=1 -> INIT. err_count is cleared, step=0, busy=1 from the next cycle.
- INIT: s_out=0, r_out=1 for HOLD_CYCLES, to force a known state. No check. -> INIT_REL.
- INIT_REL: s_out=r_out=0. Expect q=0, qn=1. -> DRIVE.
- DRIVE: (s_out,r_out) = (step[1],step[0]). Expected (q,qn) per step:
  - step 0 (0,0): expect (0,1), held from INIT.
  - step 1 (0,1): expect (0,1).
  - step 2 (1,0): expect (1,0).
  - step 3 (1,1): expect (0,0), the forbidden state of a NOR latch.
  - -> RELEASE.
- RELEASE: s_out=r_out=0.
  - Steps 0–1 expect (0,1). Step 2 expects (1,0).
  - Step 3 is not checked, because the (1,1)->(0,0) release is a race.
  - If step<3: step+1 -> DRIVE. If step==3 -> DONE.
- Totals: 8 checks per run. A mismatch on either bit increments err_count by 1, saturating at 15.
- DONE:
  - busy=0, done=1, pass=(err_count==0). s_out=r_out=0. Outputs hold.
  - start=1 -> INIT with done and pass cleared.
  - If LOOP=1, the FSM goes to INIT automatically after 1 cycle in DONE.
- Timing:
  - A run lasts 10*HOLD_CYCLES cycles, made of INIT, INIT_REL and 4×(DRIVE+RELEASE).
  - done rises exactly 10*HOLD_CYCLES+1 cycles after the edge that sampled start.
- start while busy is ignored.
- start and reset in the same cycle: reset wins.

Decomposition:
- Shared package sr_exerciser_pkg holds:
  - localparams for the FSM state encoding;
  - the expected-value table, indexed by {phase, step} and giving {q,qn, check_en};
  - the ERR_MAX=15 constant.
- Sub-module: sync_2ff, a 2-bit wide two-flop synchroniser with synchronous reset to 0. It is instantiated once for {q_in,qn_in}.

Test Plan:
- Behavioural NOR latch model; HOLD_CYCLES=10; start pulse -> done=1 at cycle 101, pass=1, err_count=0; s_out/r_out trace (0,1),(0,0),(0,0),(0,0),(0,1),(0,0),(1,0),(0,0),(1,1),(0,0).
- q_in stuck at 0 (qn from model) -> failing checks are DRIVE2 and REL2; err_count=2, pass=0.
- NAND-style model returning (1,1) on s=r=1 -> only DRIVE3 fails; err_count=1.
- Reset asserted at cycle 37 mid-run -> next edge all outputs 0, FSM in IDLE; a new start then completes with pass=1.
- start re-pulsed at cycle 50 while busy -> ignored; done still rises at cycle 101. Start pulse while done=1 -> done clears next cycle and a new run begins.
- LOOP=1 with q_in stuck at 1 -> err_count cleared to 0 at each auto-restart; done pulses 1 cycle every 10*HOLD_CYCLES+2 cycles; err_count at each done = 6.
